// File: rtl/a_hub_if.sv
// Handshake bundle between the hub and its two peers b and c.
// The hub side uses the slave modport; a peer model (or bench) uses master.
interface a_hub_if #(
  parameter int B_W   = 4,
  parameter int C_W   = 13,
  parameter int SEQ_W = 5
);
  logic [B_W-1:0]       b_a_dat;
  logic                 b_a_vld;
  logic                 a_b_rdy;

  logic [SEQ_W+B_W-1:0] a_c_dat;
  logic                 a_c_vld;
  logic                 c_a_rdy;

  logic [C_W-1:0]       c_a_dat;
  logic                 c_a_vld;
  logic                 a_c_rdy;

  logic [SEQ_W+C_W-1:0] a_b_dat;
  logic                 a_b_vld;
  logic                 b_a_rdy;

  modport slave (
    input  b_a_dat, b_a_vld, c_a_rdy, c_a_dat, c_a_vld, b_a_rdy,
    output a_b_rdy, a_c_dat, a_c_vld, a_c_rdy, a_b_dat, a_b_vld
  );

  modport master (
    output b_a_dat, b_a_vld, c_a_rdy, c_a_dat, c_a_vld, b_a_rdy,
    input  a_b_rdy, a_c_dat, a_c_vld, a_c_rdy, a_b_dat, a_b_vld
  );
endinterface

// File: rtl/a_hub.sv
// Peer hub: two independent tagged elastic FIFOs (b->c and c->b) with
// per-input handshake-protocol checking, a sticky error flag and an idle flag.
module a_hub_chan #(
  parameter int W     = 4,
  parameter int SEQ_W = 5,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       in_dat_i,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  output logic [SEQ_W+W-1:0] out_dat_o,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic               empty_o,
  output logic               viol_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = SEQ_W + W;

  logic [OW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [SEQ_W-1:0] tag_q, tag_d;
  logic             stall_q, stall_d;
  logic [W-1:0]     hist_q;

  logic full, empty, push, pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  // A full FIFO refuses the word even when a pop frees a slot this cycle.
  assign push  = in_vld_i & ~full;
  assign pop   = out_rdy_i & ~empty;

  assign in_rdy_o  = ~full;
  assign out_vld_o = ~empty;
  assign out_dat_o = mem_q[rd_ptr_q];
  assign empty_o   = empty;

  // A stalled word must be held unchanged until it is accepted.
  assign viol_o = stall_q & (~in_vld_i | (in_dat_i != hist_q));

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    tag_d    = tag_q + SEQ_W'(push);
    stall_d  = in_vld_i & full;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      stall_q  <= 1'b0;
      hist_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      stall_q  <= stall_d;
      hist_q   <= in_dat_i;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tag_q, in_dat_i};
    end
  end
endmodule

module a_hub #(
  parameter int B_W   = 4,
  parameter int C_W   = 13,
  parameter int SEQ_W = 5,
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  a_hub_if.slave  hub,
  input  logic    top_a_clr,
  output logic    a_out_err,
  output logic    a_out_idle
);
  logic empty_bc, empty_cb;
  logic viol_bc, viol_cb;
  logic err_q, err_d;

  a_hub_chan #(
    .W     (B_W),
    .SEQ_W (SEQ_W),
    .DEPTH (DEPTH)
  ) u_bc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat_i  (hub.b_a_dat),
    .in_vld_i  (hub.b_a_vld),
    .in_rdy_o  (hub.a_b_rdy),
    .out_dat_o (hub.a_c_dat),
    .out_vld_o (hub.a_c_vld),
    .out_rdy_i (hub.c_a_rdy),
    .empty_o   (empty_bc),
    .viol_o    (viol_bc)
  );

  a_hub_chan #(
    .W     (C_W),
    .SEQ_W (SEQ_W),
    .DEPTH (DEPTH)
  ) u_cb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat_i  (hub.c_a_dat),
    .in_vld_i  (hub.c_a_vld),
    .in_rdy_o  (hub.a_c_rdy),
    .out_dat_o (hub.a_b_dat),
    .out_vld_o (hub.a_b_vld),
    .out_rdy_i (hub.b_a_rdy),
    .empty_o   (empty_cb),
    .viol_o    (viol_cb)
  );

  // A new violation takes priority over a clear arriving in the same cycle.
  always_comb begin
    err_d = err_q;
    if (viol_bc | viol_cb) begin
      err_d = 1'b1;
    end else if (top_a_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign a_out_err  = err_q;
  assign a_out_idle = empty_bc & empty_cb;
endmodule

// File: tb/tb_a_hub.sv
// Scoreboard bench for a_hub: a queue-based model of both channels, directed
// scenarios plus a randomized phase that respects the hold-while-stalled rule.
module tb_a_hub;
  localparam int B_W   = 4;
  localparam int C_W   = 13;
  localparam int SEQ_W = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic top_a_clr;
  logic a_out_err;
  logic a_out_idle;

  a_hub_if #(.B_W(B_W), .C_W(C_W), .SEQ_W(SEQ_W)) bus ();

  a_hub #(.B_W(B_W), .C_W(C_W), .SEQ_W(SEQ_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hub        (bus),
    .top_a_clr  (top_a_clr),
    .a_out_err  (a_out_err),
    .a_out_idle (a_out_idle)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [SEQ_W+B_W-1:0] qb [$];
  logic [SEQ_W+C_W-1:0] qc [$];
  logic [SEQ_W-1:0]     tag_b, tag_c;
  logic                 stall_b, stall_c;
  logic [B_W-1:0]       hist_b;
  logic [C_W-1:0]       hist_c;
  logic                 err_m, err_snap;
  int                   pre_b, pre_c;

  // Stimulus-to-monitor signalling
  int   tmo = 0;
  int   done = 0;
  int   async_req = 0;
  logic async_vld = 1'b0;

  // Monitor-owned counters
  int n_cmp = 0;
  int n_bad = 0;
  int async_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model update: decides what the upcoming rising edge does, from inputs only.
  always @(negedge clk) begin
    logic viol, acc;
    if (!rst_n) begin
      qb.delete();
      qc.delete();
      tag_b = '0; tag_c = '0;
      stall_b = 1'b0; stall_c = 1'b0;
      hist_b = '0; hist_c = '0;
      err_m = 1'b0; err_snap = 1'b0;
      pre_b = 0; pre_c = 0;
    end else begin
      pre_b    = qb.size();
      pre_c    = qc.size();
      err_snap = err_m;
      viol = (stall_b && (!bus.b_a_vld || bus.b_a_dat != hist_b)) ||
             (stall_c && (!bus.c_a_vld || bus.c_a_dat != hist_c));
      acc = bus.b_a_vld && (pre_b < DEPTH);
      if (acc) begin
        qb.push_back({tag_b, bus.b_a_dat});
        tag_b = tag_b + 1'b1;
      end
      stall_b = bus.b_a_vld && !acc;
      hist_b  = bus.b_a_dat;
      acc = bus.c_a_vld && (pre_c < DEPTH);
      if (acc) begin
        qc.push_back({tag_c, bus.c_a_dat});
        tag_c = tag_c + 1'b1;
      end
      stall_c = bus.c_a_vld && !acc;
      hist_c  = bus.c_a_dat;
      if (viol) err_m = 1'b1;
      else if (top_a_clr) err_m = 1'b0;
    end
  end

  // Monitor: compares DUT outputs with the model and pops on every handshake.
  always @(negedge clk) begin
    logic [SEQ_W+B_W-1:0] eb;
    logic [SEQ_W+C_W-1:0] ec;
    #1;
    if (async_req != async_seen) begin
      chk("async_reset_vld", 32'(async_vld), 32'd0);
      async_seen = async_req;
    end
    if (!rst_n) begin
      chk("rst_a_c_vld", 32'(bus.a_c_vld), 32'd0);
      chk("rst_a_b_vld", 32'(bus.a_b_vld), 32'd0);
      chk("rst_a_b_rdy", 32'(bus.a_b_rdy), 32'd1);
      chk("rst_a_c_rdy", 32'(bus.a_c_rdy), 32'd1);
      chk("rst_err",     32'(a_out_err),   32'd0);
      chk("rst_idle",    32'(a_out_idle),  32'd1);
    end else begin
      chk("a_b_rdy", 32'(bus.a_b_rdy), 32'(pre_b < DEPTH));
      chk("a_c_vld", 32'(bus.a_c_vld), 32'(pre_b != 0));
      chk("a_c_rdy", 32'(bus.a_c_rdy), 32'(pre_c < DEPTH));
      chk("a_b_vld", 32'(bus.a_b_vld), 32'(pre_c != 0));
      chk("err",     32'(a_out_err),   32'(err_snap));
      chk("idle",    32'(a_out_idle),  32'(pre_b == 0 && pre_c == 0));
      if (pre_b != 0 && bus.c_a_rdy) begin
        eb = qb.pop_front();
        chk("a_c_dat", 32'(bus.a_c_dat), 32'(eb));
        $display("[%0t] b->c pop tag=%0d dat=0x%0h", $time, eb[SEQ_W+B_W-1:B_W], eb[B_W-1:0]);
      end
      if (pre_c != 0 && bus.b_a_rdy) begin
        ec = qc.pop_front();
        chk("a_b_dat", 32'(bus.a_b_dat), 32'(ec));
        $display("[%0t] c->b pop tag=%0d dat=0x%0h", $time, ec[SEQ_W+C_W-1:C_W], ec[C_W-1:0]);
      end
    end
    if (done != 0) begin
      chk("handshake_timeouts", 32'(tmo), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected done by t=300000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_b(input logic [B_W-1:0] d);
    logic acc;
    bus.b_a_vld = 1'b1;
    bus.b_a_dat = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acc = bus.a_b_rdy;
      tick();
      if (acc) break;
      if (i == 59) tmo++;
    end
    bus.b_a_vld = 1'b0;
  endtask

  task automatic send_c(input logic [C_W-1:0] d);
    logic acc;
    bus.c_a_vld = 1'b1;
    bus.c_a_dat = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acc = bus.a_c_rdy;
      tick();
      if (acc) break;
      if (i == 59) tmo++;
    end
    bus.c_a_vld = 1'b0;
  endtask

  task automatic stream_b(input int n);
    logic acc;
    int sent = 0;
    int guard = 0;
    bus.b_a_vld = 1'b1;
    bus.b_a_dat = B_W'($urandom);
    while (sent < n && guard < 1000) begin
      @(negedge clk);
      acc = bus.a_b_rdy;
      tick();
      guard++;
      if (acc) begin
        sent++;
        bus.b_a_dat = B_W'($urandom);
      end
    end
    if (guard >= 1000) tmo++;
    bus.b_a_vld = 1'b0;
  endtask

  task automatic random_phase(input int n);
    logic sb, sc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sb = bus.b_a_vld & ~bus.a_b_rdy;
      sc = bus.c_a_vld & ~bus.a_c_rdy;
      tick();
      if (!sb) begin
        bus.b_a_vld = ($urandom % 4) != 0;
        bus.b_a_dat = B_W'($urandom);
      end
      if (!sc) begin
        bus.c_a_vld = ($urandom % 4) != 0;
        bus.c_a_dat = C_W'($urandom);
      end
      bus.c_a_rdy = ($urandom % 3) != 0;
      bus.b_a_rdy = ($urandom % 3) != 0;
    end
  endtask

  initial begin
    bus.b_a_vld = 1'b0; bus.b_a_dat = '0;
    bus.c_a_vld = 1'b0; bus.c_a_dat = '0;
    bus.c_a_rdy = 1'b1; bus.b_a_rdy = 1'b1;
    top_a_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // First word after reset: tag 0, visible one cycle after the push
    bus.c_a_rdy = 1'b0;
    send_b(4'hA);
    tick();
    bus.c_a_rdy = 1'b1;
    repeat (2) tick();

    // Fill c->b while b stalls; a fifth word is refused until a pop
    bus.b_a_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) send_c(C_W'(i));
    bus.c_a_vld = 1'b1;
    bus.c_a_dat = 13'h005;
    repeat (3) tick();
    bus.b_a_rdy = 1'b1;
    send_c(13'h005);
    repeat (6) tick();

    // Push and pop together with two words resident
    bus.c_a_rdy = 1'b0;
    send_b(4'h1);
    send_b(4'h2);
    bus.c_a_rdy = 1'b1;
    stream_b(10);
    repeat (4) tick();

    // Tag wrap: 33 words from a fresh reset
    do_reset();
    stream_b(33);
    repeat (3) tick();

    random_phase(300);
    bus.b_a_vld = 1'b0;
    bus.c_a_vld = 1'b0;
    bus.b_a_rdy = 1'b1;
    bus.c_a_rdy = 1'b1;
    tick();
    top_a_clr = 1'b1;
    tick();
    top_a_clr = 1'b0;
    repeat (8) tick();

    // Protocol error: change data while stalled, clear, then violate during clear
    bus.c_a_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_b(B_W'(i + 8));
    bus.b_a_vld = 1'b1;
    bus.b_a_dat = 4'h5;
    repeat (2) tick();
    bus.b_a_dat = 4'h6;
    repeat (3) tick();
    top_a_clr = 1'b1;
    tick();
    top_a_clr = 1'b0;
    tick();
    bus.b_a_dat = 4'h7;
    top_a_clr = 1'b1;
    tick();
    top_a_clr = 1'b0;
    repeat (2) tick();
    bus.c_a_rdy = 1'b1;
    send_b(4'h7);
    top_a_clr = 1'b1;
    tick();
    top_a_clr = 1'b0;
    repeat (6) tick();

    // Reset mid-stream with three words stored
    bus.c_a_rdy = 1'b0;
    send_b(4'h1);
    send_b(4'h2);
    send_b(4'h3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 async_vld = bus.a_c_vld | bus.a_b_vld;
    async_req++;
    repeat (2) tick();
    rst_n = 1'b1;
    send_b(4'hC);
    bus.c_a_rdy = 1'b1;
    repeat (4) tick();
    done = 1;
  end
endmodule

// File: doc/a_hub.md
# a_hub

Parametrised peer hub between blocks b and c: carries b's data to c and c's data to b through independent elastic FIFOs with valid/ready handshakes. Each forwarded word is tagged with a per-direction wrapping sequence number. A sticky protocol-error flag and an idle flag go to top level. Successor of the fixed-width, port-only a-peer block; widths, depth and tag size are all generic.

## Interface
- B_W, 4: data width b→a (forwarded to c)
- C_W, 13: data width c→a (forwarded to b)
- SEQ_W, 5: sequence tag width, ≥1
- DEPTH, 4: entries per FIFO; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- b_a_dat  in  B_W  data from b
- b_a_vld  in  1  b data valid
- a_b_rdy  out  1  a can accept from b
- a_c_dat  out  SEQ_W+B_W  {tag, b data} to c
- a_c_vld  out  1  data to c valid
- c_a_rdy  in  1  c accepts
- c_a_dat  in  C_W  data from c
- c_a_vld  in  1  c data valid
- a_c_rdy  out  1  a can accept from c
- a_b_dat  out  SEQ_W+C_W  {tag, c data} to b
- a_b_vld  out  1  data to b valid
- b_a_rdy  in  1  b accepts
- top_a_clr  in  1  clears sticky error
- a_out_err  out  1  sticky protocol error
- a_out_idle  out  1  both FIFOs empty

## Operation
- Two identical channels: B→C (in b_a_*, out a_c_*) and C→B (in c_a_*, out a_b_*).
- Push: in_vld & in_rdy at a rising edge. Pop: out_vld & out_rdy.
- in_rdy = !full, combinational from occupancy. A full FIFO does not accept, even if a pop occurs in the same cycle.
- out_vld = !empty. out_dat is the head entry (first-word fall-through from storage); it is stable while out_vld & !out_rdy.
- Push and pop in the same cycle (not full, not empty): occupancy unchanged.
- Occupancy is held in a log2(DEPTH)+1 bit counter. Read and write pointers are log2(DEPTH) bits and wrap DEPTH-1→0.
- Tag:
  - Each channel has an SEQ_W-bit counter, captured into the entry on push and incremented on push.
  - Wraps 2^SEQ_W-1→0.
  - The first word after reset carries tag 0.
- Protocol check per input: error if, in the previous cycle, in_vld=1 and in_rdy=0, and this cycle in_vld=0 or in_dat differs from the previous cycle. The check needs one registered copy of vld/dat/stall per input.
- a_out_err:
  - Set on any check failure.
  - Cleared by top_a_clr=1; set wins if both occur in the same cycle.
  - Holds otherwise.
- a_out_idle = both FIFOs empty.

## Timing
- Reset (async assert, synchronous-to-clk deassert handled externally) clears all of the following:
  - pointers, occupancy, tag counters, protocol-check history;
  - a_c_vld=0, a_b_vld=0, a_b_rdy=1, a_c_rdy=1, a_out_err=0, a_out_idle=1.
- a_c_dat and a_b_dat are don't-care while vld=0; the bench checks them only when vld=1.
- Latency:
  - A word pushed at edge N appears on the output with vld=1 after edge N; it can be popped at edge N+1.
  - Minimum latency is 1 cycle.
- Throughput: 1 word/cycle per channel, sustained when the output is always ready.
- rdy falls after the edge that fills the FIFO and rises after the edge that pops from full.
- a_out_err rises one cycle after the offending edge.
- A reset asserted mid-transfer discards all stored words immediately; tags restart at 0.

## Test plan
- Reset, then idle:
  - All outputs at their reset values; a_out_idle=1.
  - After one push of b_a_dat=4'hA: a_c_vld=1 and a_c_dat={5'd0,4'hA} the next cycle; a_out_idle=0.
- Fill C→B with c_a_rdy... b_a_rdy=0, DEPTH=4:
  - After pushes 13'h001..13'h004: a_c_rdy=0, and a 5th word is not accepted.
  - Raise b_a_rdy: pops return tags 0..3 in order; a_c_rdy=1 after the first pop.
- Simultaneous push/pop at occupancy 2 for 10 cycles: occupancy stays 2; data and tag order preserved.
- Tag wrap with SEQ_W=5: 33 words through B→C carry tags 0..31 then 0.
- Protocol error:
  - Hold b_a_vld=1 while full, then change b_a_dat: a_out_err=1 next cycle and stays 1.
  - top_a_clr pulse clears it.
  - A violation and a clear in the same cycle leave err=1.
- Reset mid-stream with 3 words stored: vld drops to 0 asynchronously; after release, a new word carries tag 0.
